uc_secuencial: RTL

//  Sequencing control unit for the 8-bit single-issue CPU datapath (cd). Decodes opcode[5:0] and the

---
 rtl/uc_secuencial_if.sv | 42 ++++
 rtl/uc_secuencial.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uc_secuencial_if.sv
// Control bundle between the sequencing unit and the CPU datapath.
// master = control unit (drives strobes/selects), slave = datapath side.
interface uc_secuencial_if;
  logic       run;
  logic [5:0] opcode;
  logic       z;
  logic       pc_we;
  logic       s_inc;
  logic       selectorMuxSaltoR;
  logic       s_inm;
  logic       we3;
  logic       wez;
  logic [2:0] op_alu;
  logic       guardarMemoriaDatos;
  logic       selectorMuxDireccionMemoriaDatos;
  logic       activarPilaSubRutinas;
  logic       pushPilaSubRutinas;
  logic       selectorMuxPilaSubRutinas;
  logic       activarPilaDatos;
  logic       pushPilaDatos;
  logic       selectorMuxPilaDatos;
  logic       halted;
  logic [1:0] error_code;

  modport master (
    input  run, opcode, z,
    output pc_we, s_inc, selectorMuxSaltoR, s_inm, we3, wez, op_alu,
           guardarMemoriaDatos, selectorMuxDireccionMemoriaDatos,
           activarPilaSubRutinas, pushPilaSubRutinas, selectorMuxPilaSubRutinas,
           activarPilaDatos, pushPilaDatos, selectorMuxPilaDatos,
           halted, error_code
  );

  modport slave (
    output run, opcode, z,
    input  pc_we, s_inc, selectorMuxSaltoR, s_inm, we3, wez, op_alu,
           guardarMemoriaDatos, selectorMuxDireccionMemoriaDatos,
           activarPilaSubRutinas, pushPilaSubRutinas, selectorMuxPilaSubRutinas,
           activarPilaDatos, pushPilaDatos, selectorMuxPilaDatos,
           halted, error_code
  );
endinterface

// File: rtl/uc_secuencial.sv
// Sequencing control unit: decodes opcode/z into datapath strobes, tracks stack
// depths, stretches LD/POP into a write-back cycle and freezes on HALT or fault.
module uc_secuencial #(
  parameter int SUB_DEPTH  = 8,
  parameter int DATA_DEPTH = 16
) (
  input logic              clk,
  input logic              reset,
  uc_secuencial_if.master  bus
);
  localparam int SUB_W  = $clog2(SUB_DEPTH + 1);
  localparam int DATA_W = $clog2(DATA_DEPTH + 1);
  localparam logic [SUB_W-1:0]  SUB_MAX  = SUB_W'(SUB_DEPTH);
  localparam logic [DATA_W-1:0] DATA_MAX = DATA_W'(DATA_DEPTH);
  localparam logic [SUB_W-1:0]  SUB_ONE  = SUB_W'(1);
  localparam logic [DATA_W-1:0] DATA_ONE = DATA_W'(1);

  typedef enum logic [2:0] {S_INIT, S_RUN, S_WB, S_HALT, S_ERR} state_t;

  state_t              state_reg, state_next;
  logic [SUB_W-1:0]    sub_depth_reg, sub_depth_next;
  logic [DATA_W-1:0]   data_depth_reg, data_depth_next;
  logic [1:0]          err_reg, err_next;

  logic       pc_we, s_inc, salto_r, s_inm, we3, wez;
  logic [2:0] op_alu;
  logic       mem_we, mem_addr_sel;
  logic       sub_act, sub_push, sub_sel;
  logic       dat_act, dat_push, dat_sel;
  logic       fault;
  logic [1:0] fault_code;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= S_INIT;
      sub_depth_reg  <= '0;
      data_depth_reg <= '0;
      err_reg        <= 2'b00;
    end else begin
      state_reg      <= state_next;
      sub_depth_reg  <= sub_depth_next;
      data_depth_reg <= data_depth_next;
      err_reg        <= err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    sub_depth_next  = sub_depth_reg;
    data_depth_next = data_depth_reg;
    err_next        = err_reg;
    pc_we        = 1'b0;
    s_inc        = 1'b1;
    salto_r      = 1'b0;
    s_inm        = 1'b0;
    we3          = 1'b0;
    wez          = 1'b0;
    op_alu       = 3'b000;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    sub_act      = 1'b0;
    sub_push     = 1'b0;
    sub_sel      = 1'b0;
    dat_act      = 1'b0;
    dat_push     = 1'b0;
    dat_sel      = 1'b0;
    fault        = 1'b0;
    fault_code   = 2'b00;

    case (state_reg)
      S_INIT: begin
        if (bus.run) state_next = S_RUN;
      end
      S_RUN: begin
        if (bus.run) begin
          pc_we = 1'b1;
          casez (bus.opcode)
            6'b0?????: begin
              op_alu = bus.opcode[4:2];
              we3    = 1'b1;
              wez    = 1'b1;
            end
            6'b1000??: begin
              s_inm = 1'b1;
              we3   = 1'b1;
            end
            6'b10010?: begin
              mem_addr_sel = 1'b1;
              pc_we        = 1'b0;
              state_next   = S_WB;
            end
            6'b1010??: mem_we = 1'b1;
            6'b110000: s_inc = 1'b0;
            6'b110001: s_inc = ~bus.z;
            6'b110010: s_inc = bus.z;
            6'b110011: salto_r = 1'b1;
            6'b110100: begin
              if (sub_depth_reg == SUB_MAX) begin
                fault      = 1'b1;
                fault_code = 2'b01;
              end else begin
                sub_act        = 1'b1;
                sub_push       = 1'b1;
                s_inc          = 1'b0;
                sub_depth_next = sub_depth_reg + SUB_ONE;
              end
            end
            6'b110101: begin
              if (sub_depth_reg == '0) begin
                fault      = 1'b1;
                fault_code = 2'b10;
              end else begin
                sub_act        = 1'b1;
                sub_sel        = 1'b1;
                sub_depth_next = sub_depth_reg - SUB_ONE;
              end
            end
            6'b1110??: begin
              if (data_depth_reg == DATA_MAX) begin
                fault      = 1'b1;
                fault_code = 2'b11;
              end else begin
                dat_act         = 1'b1;
                dat_push        = 1'b1;
                data_depth_next = data_depth_reg + DATA_ONE;
              end
            end
            6'b111100: begin
              if (data_depth_reg == '0) begin
                fault      = 1'b1;
                fault_code = 2'b11;
              end else begin
                dat_act         = 1'b1;
                dat_sel         = 1'b1;
                pc_we           = 1'b0;
                state_next      = S_WB;
                data_depth_next = data_depth_reg - DATA_ONE;
              end
            end
            6'b111111: begin
              pc_we      = 1'b0;
              state_next = S_HALT;
            end
            default: ;
          endcase
          // A faulting instruction only ever set pc_we, so dropping it leaves idle outputs.
          if (fault) begin
            pc_we      = 1'b0;
            err_next   = fault_code;
            state_next = S_ERR;
          end
        end
      end
      S_WB: begin
        if (bus.run) begin
          we3        = 1'b1;
          pc_we      = 1'b1;
          state_next = S_RUN;
        end
      end
      default: ;
    endcase
  end

  assign bus.pc_we                            = pc_we;
  assign bus.s_inc                            = s_inc;
  assign bus.selectorMuxSaltoR                = salto_r;
  assign bus.s_inm                            = s_inm;
  assign bus.we3                              = we3;
  assign bus.wez                              = wez;
  assign bus.op_alu                           = op_alu;
  assign bus.guardarMemoriaDatos              = mem_we;
  assign bus.selectorMuxDireccionMemoriaDatos = mem_addr_sel;
  assign bus.activarPilaSubRutinas            = sub_act;
  assign bus.pushPilaSubRutinas               = sub_push;
  assign bus.selectorMuxPilaSubRutinas        = sub_sel;
  assign bus.activarPilaDatos                 = dat_act;
  assign bus.pushPilaDatos                    = dat_push;
  assign bus.selectorMuxPilaDatos             = dat_sel;
  assign bus.halted                           = (state_reg == S_HALT) || (state_reg == S_ERR);
  assign bus.error_code                       = err_reg;
endmodule
